pwm_multi: RTL and testbench

- Parametrised multi-channel PWM generator. Successor to the single-channel 3-bit uptime PWM.
- One shared period counter drives CHANNELS independent duty comparators.
- Period and duty values are written through a simple chip-select register port into shadow registers. Shadows are applied atomically at the period boundary, so output waveforms never glitch.
- Sits between the control bus and clock/motor/LED drivers.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_chan.sv | 53 +++++
 rtl/pwm_multi.sv | 132 +++++++++++++
 tb/tb_pwm_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared register map constants and counter direction type for the
//           multi-channel PWM generator.
// Revision: 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int ADDR_PERIOD    = 0;
    localparam int ADDR_DUTY_BASE = 1;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/pwm_chan.sv
`default_nettype none
// ============================================================================
// Module  : pwm_chan
// Brief   : One PWM channel: duty shadow/active registers, comparator and
//           registered output.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4,
    parameter int INDEX = 0
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             enable,
    input  logic             cs,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    output logic             clkout
);

    localparam logic [AW-1:0] c_addr = AW'(ADDR_DUTY_BASE + INDEX);

    logic             w_sel;
    logic [WIDTH-1:0] r_duty_shd;
    logic [WIDTH-1:0] r_duty_act;

    assign w_sel = cs && (addr == c_addr);

    // Active register samples the pre-write shadow, so a write on the wrap
    // edge only becomes visible one period later.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_duty_shd <= '0;
            r_duty_act <= '0;
            clkout     <= 1'b0;
        end else begin
            if (w_sel) begin
                r_duty_shd <= wdata;
            end
            if (load) begin
                r_duty_act <= r_duty_shd;
            end
            clkout <= enable && (cnt < r_duty_act);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module  : pwm_multi
// Brief   : Multi-channel PWM generator with shared period counter and
//           glitch-free shadowed period/duty registers. Optional centre-aligned
//           counting is enabled by defining PWM_CENTER_ALIGN_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int AW       = 4
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                enable,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                center,
`endif
    input  logic                cs,
    input  logic [AW-1:0]       addr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [CHANNELS-1:0] clkout,
    output logic                period_tick
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_period_shd;
    logic [WIDTH-1:0] r_period_act;
    logic             w_wrap;
    logic             w_load;
    logic             w_period_wr;

    assign w_period_wr = cs && (addr == AW'(ADDR_PERIOD));
    // While stopped the active registers follow their shadows every cycle.
    assign w_load      = w_wrap || !enable;

`ifdef PWM_CENTER_ALIGN_EN
    logic r_center;
    dir_t r_dir;
    dir_t w_dir_nxt;
    logic w_center_mode;

    assign w_center_mode = r_center && (r_period_act != '0);
`endif

    always_comb begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
        w_wrap    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        w_dir_nxt = r_dir;
`endif
        if (!enable) begin
            w_cnt_nxt = '0;
`ifdef PWM_CENTER_ALIGN_EN
            w_dir_nxt = UP;
`endif
        end
`ifdef PWM_CENTER_ALIGN_EN
        // With a period of 1 the turning point and the wrap coincide at cnt=1.
        else if (w_center_mode) begin
            if ((r_cnt == WIDTH'(1)) && ((r_dir == DOWN) || (r_period_act == WIDTH'(1)))) begin
                w_wrap    = 1'b1;
                w_cnt_nxt = '0;
                w_dir_nxt = UP;
            end else if ((r_dir == DOWN) || (r_cnt == r_period_act)) begin
                w_cnt_nxt = r_cnt - WIDTH'(1);
                w_dir_nxt = DOWN;
            end
        end
`endif
        else if (r_cnt == r_period_act) begin
            w_wrap    = 1'b1;
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_period_shd <= '0;
            r_period_act <= '0;
            period_tick  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_period_wr) begin
                r_period_shd <= wdata;
            end
            if (w_load) begin
                r_period_act <= r_period_shd;
            end
            period_tick <= w_wrap;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_dir    <= UP;
            r_center <= 1'b0;
        end else begin
            r_dir <= w_dir_nxt;
            if (w_load) begin
                r_center <= center;
            end
        end
    end
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        pwm_chan #(
            .WIDTH (WIDTH),
            .AW    (AW),
            .INDEX (gi)
        ) u_chan (
            .clkin  (clkin),
            .reset  (reset),
            .enable (enable),
            .cs     (cs),
            .addr   (addr),
            .wdata  (wdata),
            .load   (w_load),
            .cnt    (r_cnt),
            .clkout (clkout[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_multi
// Brief   : Self-checking bench for pwm_multi against a period/phase-based
//           reference model, directed scenarios followed by random traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int AW       = 4;

    logic                clkin = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic                center = 1'b0;
    logic                cs = 1'b0;
    logic [AW-1:0]       addr = '0;
    logic [WIDTH-1:0]    wdata = '0;
    logic [CHANNELS-1:0] clkout;
    logic                period_tick;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position within the period plus shadow/active values.
    int   m_phase;
    int   m_pshd, m_pact;
    int   m_dshd [CHANNELS];
    int   m_dact [CHANNELS];
    logic m_cact;
    logic [CHANNELS-1:0] m_out;
    logic m_tick;

    pwm_multi #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .AW       (AW)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .enable      (enable),
`ifdef PWM_CENTER_ALIGN_EN
        .center      (center),
`endif
        .cs          (cs),
        .addr        (addr),
        .wdata       (wdata),
        .clkout      (clkout),
        .period_tick (period_tick)
    );

    always #5 clkin = ~clkin;

    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pshd  = 0;
        m_pact  = 0;
        m_cact  = 1'b0;
        m_out   = '0;
        m_tick  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            m_dshd[i] = 0;
            m_dact[i] = 0;
        end
    endtask

    // One clock edge: outputs derive from the period length and the counter
    // value implied by the phase (triangle profile in centre mode).
    task automatic model_edge();
        int  len;
        int  c;
        bit  cm;
        bit  endp;
        cm   = m_cact && (m_pact != 0);
        len  = cm ? 2 * m_pact : m_pact + 1;
        c    = (m_phase <= m_pact) ? m_phase : 2 * m_pact - m_phase;
        endp = enable && (m_phase == len - 1);
        m_tick = endp;
        for (int i = 0; i < CHANNELS; i++) begin
            m_out[i] = enable && (c < m_dact[i]);
        end
        if (!enable || endp) begin
            m_pact  = m_pshd;
            m_dact  = m_dshd;
            m_cact  = center;
            m_phase = 0;
        end else begin
            m_phase++;
        end
        if (cs) begin
            if (int'(addr) == 0) begin
                m_pshd = int'(wdata);
            end else if (int'(addr) <= CHANNELS) begin
                m_dshd[int'(addr) - 1] = int'(wdata);
            end
        end
    endtask

    task automatic step();
        @(posedge clkin);
        model_edge();
        #1;
        chk_value("period_tick", 32'(period_tick), 32'(m_tick));
        chk_value("clkout", 32'(clkout), 32'(m_out));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int a, input int d);
        cs    = 1'b1;
        addr  = AW'(a);
        wdata = WIDTH'(d);
        step();
        cs    = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        int guard = 0;
        while (m_phase != ph && guard < 300) begin
            step();
            guard++;
        end
        if (m_phase != ph) begin
            n_err++;
            $display("FAIL wait_phase: phase %0d never reached (now %0d)", ph, m_phase);
        end
    endtask

    // Asynchronous reset asserted between edges must clear outputs at once.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk_value("async_rst_tick", 32'(period_tick), 32'(0));
        chk_value("async_rst_clkout", 32'(clkout), 32'(0));
        @(posedge clkin);
        #1;
        reset = 1'b1;
        chk_value("rst_hold_clkout", 32'(clkout), 32'(0));
    endtask

    task automatic count_window(input int n, input int ch, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            highs += int'(clkout[ch]);
            ticks += int'(period_tick);
        end
    endtask

    initial begin
        int h, t;
        model_reset();
        repeat (2) @(posedge clkin);
        #1;
        chk_value("reset_tick", 32'(period_tick), 32'(0));
        chk_value("reset_clkout", 32'(clkout), 32'(0));
        reset = 1'b1;

        // Period 10, duties 0/3/10/12.
        wr(0, 9);
        wr(1, 0);
        wr(2, 3);
        wr(3, 10);
        wr(4, 12);
        enable = 1'b1;
        run(12);
        count_window(10, 1, h, t);
        chk_value("ch1_high_cycles", 32'(h), 32'(3));
        chk_value("ticks_per_10", 32'(t), 32'(1));

        // Mid-period duty update at cnt=4.
        wait_phase(4);
        wr(2, 6);
        run(25);

        // Period rewrite exactly on the wrap edge.
        wait_phase(9);
        wr(0, 4);
        run(20);

        // Degenerate one-cycle period.
        wr(0, 0);
        wr(1, 1);
        wr(2, 0);
        run(15);
        count_window(5, 0, h, t);
        chk_value("p0_ch0_high", 32'(h), 32'(5));
        chk_value("p0_ticks", 32'(t), 32'(5));

        // Enable drop at cnt=5, then reset mid-run.
        wr(0, 9);
        run(12);
        wait_phase(5);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(7);
        do_reset();
        run(10);

`ifdef PWM_CENTER_ALIGN_EN
        enable = 1'b0;
        center = 1'b1;
        wr(0, 4);
        wr(1, 2);
        step();
        enable = 1'b1;
        run(16);
        count_window(8, 0, h, t);
        chk_value("center_ch0_high", 32'(h), 32'(3));
        chk_value("center_ticks", 32'(t), 32'(1));
`endif

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cs = ($urandom_range(0, 2) == 0);
            addr = AW'($urandom_range(0, 7));
            wdata = ($urandom_range(0, 5) == 0) ? WIDTH'($urandom_range(0, 255))
                                                : WIDTH'($urandom_range(0, 11));
            if (cs && addr == '0) begin
                wdata = WIDTH'($urandom_range(0, 11));
            end
            if ($urandom_range(0, 49) == 0) enable = ~enable;
`ifdef PWM_CENTER_ALIGN_EN
            if ($urandom_range(0, 19) == 0) center = ~center;
`endif
            if ($urandom_range(0, 499) == 0) begin
                cs = 1'b0;
                do_reset();
            end else begin
                step();
            end
        end
        cs = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
